// File: rtl/cu_id_queue.sv
// RV32I instruction-decode stage: decodes fetch words on entry and buffers the
// decoded fields in a DEPTH-entry FIFO presented to the CU over valid/ready.
module cu_id_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic                       soc_clk,
    input  logic                       IDU_reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       IDU_stall,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [SHW-1:0]             shamt,
    output logic [XLEN-1:0]            imm,
    output logic [2:0]                 fmt,
    output logic                       invalid_instruction,
    output logic [15:0]                err_count,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTW = XLEN + 7 + 3 + 7 + 5 + 5 + 5 + SHW + XLEN + 3;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_INV = 3'd7;

    function automatic logic [2:0] decode_fmt(input logic [6:0] opc);
        logic [2:0] f;
        case (opc)
            7'b0110111, 7'b0010111: f = FMT_U;
            7'b1101111:             f = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: f = FMT_I;
            7'b1100011:             f = FMT_B;
            7'b0100011:             f = FMT_S;
            7'b0110011:             f = FMT_R;
            default:                f = FMT_INV;
        endcase
        return f;
    endfunction

    // The 32-bit immediate is assembled first, then sign-extended to XLEN.
    function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] ins);
        logic [31:0]             raw;
        logic signed [XLEN-1:0]  ext;
        case (decode_fmt(ins[6:0]))
            FMT_I:   raw = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   raw = {ins[31:12], 12'b0};
            FMT_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: raw = 32'd0;
        endcase
        ext = $signed(raw);
        return ext;
    endfunction

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        logic [PTRW-1:0] n;
        if (p == PTRW'(DEPTH - 1)) begin
            n = {PTRW{1'b0}};
        end else begin
            n = p + PTRW'(1);
        end
        return n;
    endfunction

    logic [ENTW-1:0] entry_mem_r [DEPTH];
    logic [PTRW-1:0] head_r;
    logic [PTRW-1:0] tail_r;
    logic [CNTW-1:0] count_r;
    logic [15:0]     err_count_r;

    logic [2:0]      dec_fmt_s;
    logic [ENTW-1:0] dec_entry_s;
    logic [ENTW-1:0] head_entry_s;
    logic            push_s;
    logic            pop_s;
    logic            ready_s;

    // Decode of the word currently offered by fetch.
    always_comb begin
        dec_fmt_s   = decode_fmt(in_instr[6:0]);
        dec_entry_s = {in_pc, in_instr[6:0], in_instr[14:12], in_instr[31:25],
                       in_instr[11:7], in_instr[19:15], in_instr[24:20],
                       in_instr[20 +: SHW], decode_imm(in_instr), dec_fmt_s};
    end

    // Handshake qualification; reset holds in_ready low while asserted.
    always_comb begin
        ready_s = IDU_reset_n & ~IDU_stall & ~flush & (count_r < CNTW'(DEPTH));
        push_s  = in_valid & ready_s;
        pop_s   = (count_r != {CNTW{1'b0}}) & out_ready & ~IDU_stall;
    end

    // Queue storage: decoded fields land at the tail on every accepted push.
    always_ff @(posedge soc_clk or negedge IDU_reset_n) begin
        if (!IDU_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_mem_r[i] <= {ENTW{1'b0}};
            end
        end else if (push_s) begin
            entry_mem_r[tail_r] <= dec_entry_s;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge soc_clk or negedge IDU_reset_n) begin
        if (!IDU_reset_n) begin
            head_r  <= {PTRW{1'b0}};
            tail_r  <= {PTRW{1'b0}};
            count_r <= {CNTW{1'b0}};
        end else if (flush) begin
            head_r  <= {PTRW{1'b0}};
            tail_r  <= {PTRW{1'b0}};
            count_r <= {CNTW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of accepted invalid words; survives flush.
    always_ff @(posedge soc_clk or negedge IDU_reset_n) begin
        if (!IDU_reset_n) begin
            err_count_r <= 16'd0;
        end else if (push_s && (dec_fmt_s == FMT_INV) && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'd1;
        end
    end

    assign head_entry_s = entry_mem_r[head_r];
    assign {out_pc, out_opcode, out_funct3, out_funct7, rd, rs1, rs2,
            shamt, imm, fmt} = head_entry_s;
    assign invalid_instruction = (fmt == FMT_INV);
    assign out_valid = (count_r != {CNTW{1'b0}});
    assign in_ready  = ready_s;
    assign count     = count_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_cu_id_queue.sv
// Self-checking bench for cu_id_queue: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_cu_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int SHW   = $clog2(XLEN);
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic              soc_clk;
    logic              IDU_reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              IDU_stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   imm;
    logic [2:0]        fmt;
    logic              invalid_instruction;
    logic [15:0]       err_count;
    logic [CNTW-1:0]   count;

    cu_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .soc_clk(soc_clk), .IDU_reset_n(IDU_reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .IDU_stall(IDU_stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .shamt(shamt), .imm(imm), .fmt(fmt),
        .invalid_instruction(invalid_instruction), .err_count(err_count), .count(count)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   m_err = 0;

    function automatic logic [2:0] exp_fmt(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        if (op == 7'h6F) return 3'd5;
        if (op inside {7'h67, 7'h03, 7'h13, 7'h0F, 7'h73}) return 3'd1;
        if (op == 7'h63) return 3'd3;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h33) return 3'd0;
        return 3'd7;
    endfunction

    function automatic logic [XLEN-1:0] exp_imm(input logic [31:0] w);
        longint v;
        case (exp_fmt(w))
            3'd1:    v = $signed(w[31:20]);
            3'd2:    v = $signed({w[31:25], w[11:7]});
            3'd3:    v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            3'd4:    v = $signed({w[31:12], 12'h000});
            3'd5:    v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: v = 0;
        endcase
        return v[XLEN-1:0];
    endfunction

    function automatic logic exp_ready();
        return IDU_reset_n && !IDU_stall && !flush && (q.size() < DEPTH);
    endfunction

    always @(posedge soc_clk or negedge IDU_reset_n) begin
        if (!IDU_reset_n) begin
            q.delete();
            m_err = 0;
        end else begin
            bit pu, po;
            pu = in_valid && exp_ready();
            po = (q.size() > 0) && out_ready && !IDU_stall;
            if (flush) begin
                q.delete();
            end else begin
                if (po) void'(q.pop_front());
                if (pu) begin
                    ent_t e;
                    e.instr = in_instr;
                    e.pc    = in_pc;
                    q.push_back(e);
                    if (exp_fmt(in_instr) == 3'd7 && m_err < 65535) m_err++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    ent_t h;
    always @(negedge soc_clk) begin
        check("out_valid", out_valid, q.size() != 0);
        check("count", count, q.size());
        check("in_ready", in_ready, exp_ready());
        check("err_count", err_count, m_err);
        if (!IDU_reset_n) begin
            check("rst_zero", |{out_pc, out_opcode, out_funct3, out_funct7, rd, rs1, rs2,
                               shamt, imm, fmt, invalid_instruction}, 1'b0);
        end else if (q.size() > 0) begin
            h = q[0];
            check("out_pc", out_pc, h.pc);
            check("out_opcode", out_opcode, h.instr[6:0]);
            check("out_funct3", out_funct3, h.instr[14:12]);
            check("out_funct7", out_funct7, h.instr[31:25]);
            check("rd", rd, h.instr[11:7]);
            check("rs1", rs1, h.instr[19:15]);
            check("rs2", rs2, h.instr[24:20]);
            check("shamt", shamt, h.instr[20 +: SHW]);
            check("imm", imm, exp_imm(h.instr));
            check("fmt", fmt, exp_fmt(h.instr));
            check("invalid", invalid_instruction, exp_fmt(h.instr) == 3'd7);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] w, input logic [XLEN-1:0] p);
        in_valid = v;
        in_instr = w;
        in_pc    = p;
    endtask

    logic [XLEN-1:0] pc_cap;
    logic [XLEN-1:0] imm_cap;

    initial begin
        IDU_reset_n = 1'b0;
        in_valid = 1'b0; in_instr = 32'd0; in_pc = '0;
        IDU_stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        tick(); tick();
        IDU_reset_n = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1'b1);
        check("post_rst_count", count, 0);

        // addi x1,x0,5
        out_ready = 1'b1;
        offer(1'b1, 32'h00500093, 32'h100);
        tick();
        offer(1'b0, 32'd0, '0);
        check("addi_valid", out_valid, 1'b1);
        check("addi_fmt", fmt, 3'd1);
        check("addi_rd", rd, 5'd1);
        check("addi_rs1", rs1, 5'd0);
        check("addi_imm", imm, 32'd5);
        check("addi_inv", invalid_instruction, 1'b0);
        tick();
        check("addi_drained", count, 0);
        check("addi_valid0", out_valid, 1'b0);

        // sw x2,8(x1) then beq x0,x0,-4 back-to-back
        offer(1'b1, 32'h0020A423, 32'h104);
        tick();
        check("sw_fmt", fmt, 3'd2);
        check("sw_rs1", rs1, 5'd1);
        check("sw_rs2", rs2, 5'd2);
        check("sw_imm", imm, 32'd8);
        offer(1'b1, 32'hFE000EE3, 32'h108);
        tick();
        offer(1'b0, 32'd0, '0);
        check("beq_fmt", fmt, 3'd3);
        check("beq_imm", imm, 32'hFFFFFFFC);
        check("beq_pc", out_pc, 32'h108);
        tick();

        // Fill to DEPTH with the consumer stalled, third word waits in fetch
        out_ready = 1'b0;
        offer(1'b1, 32'h00100093, 32'h200);
        tick();
        check("fill1_ready", in_ready, 1'b1);
        offer(1'b1, 32'h00200113, 32'h204);
        tick();
        check("full_ready", in_ready, 1'b0);
        check("full_count", count, 2);
        offer(1'b1, 32'h00300193, 32'h208);
        tick();
        check("held_count", count, 2);
        check("held_head", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        check("pop1_head", out_pc, 32'h204);
        check("pop1_count", count, 1);
        tick();
        offer(1'b0, 32'd0, '0);
        check("third_head", out_pc, 32'h208);
        check("third_rd", rd, 5'd3);
        tick();
        check("fill_drained", count, 0);

        // Three invalid words
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h00000000, XLEN'(32'h300 + 4 * i));
            tick();
            check("inv_flag", invalid_instruction, 1'b1);
            check("inv_fmt", fmt, 3'd7);
        end
        offer(1'b0, 32'd0, '0);
        tick();
        check("inv_errs", err_count, 16'd3);

        // Flush with a word offered in the same cycle
        out_ready = 1'b0;
        offer(1'b1, 32'h00100093, 32'h400);
        tick();
        offer(1'b1, 32'h00200113, 32'h404);
        tick();
        check("preflush_count", count, 2);
        flush = 1'b1;
        offer(1'b1, 32'h00000000, 32'h408);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'd0, '0);
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_errs", err_count, 16'd3);
        tick();

        // Stall for three cycles mid-stream
        out_ready = 1'b1;
        offer(1'b1, 32'h0020A423, 32'h500);
        tick();
        offer(1'b1, 32'hFE000EE3, 32'h504);
        IDU_stall = 1'b1;
        pc_cap  = out_pc;
        imm_cap = imm;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", out_pc, pc_cap);
            check("stall_imm", imm, imm_cap);
            check("stall_count", count, 1);
            check("stall_ready", in_ready, 1'b0);
        end
        IDU_stall = 1'b0;
        tick();
        offer(1'b0, 32'd0, '0);
        check("unstall_head", out_pc, 32'h504);
        tick();

        // Asynchronous reset between edges with two entries queued
        out_ready = 1'b0;
        offer(1'b1, 32'h00100093, 32'h600);
        tick();
        offer(1'b1, 32'h00000000, 32'h604);
        tick();
        offer(1'b0, 32'd0, '0);
        check("prerst_count", count, 2);
        #2;
        IDU_reset_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b0);
        check("arst_errs", err_count, 16'd0);
        check("arst_pc", out_pc, 32'd0);
        check("arst_fmt", fmt, 3'd0);
        tick();
        IDU_reset_n = 1'b1;
        #1;
        check("rel_ready", in_ready, 1'b1);
        check("rel_count", count, 0);

        // Drive err_count to saturation with invalid words at full rate
        out_ready = 1'b1;
        offer(1'b1, 32'h00000000, 32'h700);
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", err_count, 16'hFFFE);
        tick();
        check("sat_ffff", err_count, 16'hFFFF);
        tick(); tick();
        check("sat_hold", err_count, 16'hFFFF);
        offer(1'b0, 32'd0, '0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
